fd_ratio_ctrl: RTL
==================

FD_RATIO_CTRL -- requirements
Module: fd_ratio_ctrl

Interface
REQ-001 Parameter RATIO_W, default 5, SHALL set the width of the divide-ratio field.
REQ-002 Parameter DEFAULT_RATIO, default 4, SHALL set the divide ratio loaded at reset (even, 2..30).
REQ-003 Parameter SETTLE_EDGES, default 2, SHALL set the number of div_out falling edges waited after a ratio change.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 div_en  input  1  SHALL enable the divider when high.
REQ-007 req_valid  input  1  SHALL mark a ratio-change request.
REQ-008 req_ratio  input  RATIO_W  SHALL carry the requested even divide ratio.
REQ-009 req_ready  output  1  SHALL indicate the controller can accept a request.
REQ-010 div_out  output  1  SHALL be the divided clock, 50% duty.
REQ-011 cur_ratio  output  RATIO_W  SHALL report the ratio currently applied to the divider.
REQ-012 busy  output  1  SHALL be high while a ratio change is in progress.
REQ-013 err  output  1  SHALL pulse one cycle on a rejected request.

Function
REQ-014 Divider: half-period register half_q = ratio/2; counter cnt; if cnt == half_q then cnt <= 1 and div_out toggles, else cnt <= cnt+1.
REQ-015 div_en low SHALL force cnt <= 0 and div_out <= 0 on each edge; counting resumes from cnt = 0 when div_en returns high.
REQ-016 After reset release with DEFAULT_RATIO = 4, the first div_out rise SHALL occur on the 3rd rising clk edge, then toggle every 2 edges.
REQ-017 FSM states: IDLE, WAIT_EDGE, SETTLE; req_ready SHALL equal (state == IDLE); busy SHALL equal (state != IDLE).
REQ-018 Request accepted on the edge where req_valid && req_ready; req_ratio captured into pend_q.
REQ-019 Valid ratio: even and 2..30; an odd or < 2 request SHALL be consumed, err pulsed the next cycle, state stays IDLE, half_q unchanged.
REQ-020 Valid request: IDLE -> WAIT_EDGE.
REQ-021 WAIT_EDGE: on the edge where cnt == half_q and div_out == 1 (high-to-low toggle), half_q <= pend_q/2, cnt <= 1, div_out <= 0; -> SETTLE. No runt high or low pulse SHALL be produced.
REQ-022 WAIT_EDGE with div_en low: apply pend_q on the next edge (divider idle); -> SETTLE.
REQ-023 SETTLE: count div_out falling edges; after SETTLE_EDGES edges -> IDLE. With div_en low, SETTLE SHALL exit after one cycle.
REQ-024 Request equal to cur_ratio SHALL follow the full WAIT_EDGE/SETTLE sequence.
REQ-025 cur_ratio SHALL equal half_q*2 and update in the same cycle half_q changes.
REQ-026 req_valid while busy SHALL be ignored (not captured, no err).

Reset
REQ-027 On rst high at a clk edge: cnt = 0, div_out = 0, half_q = DEFAULT_RATIO/2, state = IDLE, err = 0, settle counter = 0, pend_q = DEFAULT_RATIO.
REQ-028 Reset asserted mid-change SHALL abandon the pending ratio; cur_ratio returns to DEFAULT_RATIO.
REQ-029 req_ready SHALL be high the first cycle after rst deasserts.

Structure
REQ-030 Shared package fd_pkg SHALL hold the FSM state enum, RATIO_W and the ratio-legality constants (min 2, max 30).
REQ-031 The divider SHALL be a sub-module fd_prog (clk, rst, div_en, half, load, div_out, cnt); fd_ratio_ctrl holds the FSM and handshake.

Verification
REQ-032 Reset, div_en = 1, ratio 4 -> div_out rises at edge 3, period 4 clk, cur_ratio = 4, req_ready = 1.
REQ-033 Request 8 while div_out high mid-period -> change at the next high-to-low toggle, high and low phases both 4 clk thereafter, busy for 2 falling edges, then req_ready = 1.
REQ-034 Request 7, then 0 -> err pulses one cycle each, cur_ratio stays 4, busy never asserts.
REQ-035 Request 2 with div_en = 0 -> cur_ratio = 2 two cycles after accept, busy clears one cycle later, div_out stays 0.
REQ-036 Request 12 while busy with an earlier request for 6 -> 12 ignored, final cur_ratio = 6.
REQ-037 rst pulse during WAIT_EDGE after a request for 10 -> cur_ratio = 4, state IDLE, div_out = 0.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared types and constants for the fractional-free programmable clock divider
// and its ratio-change controller.
package fd_pkg;

  localparam int FD_RATIO_W = 5;
  localparam int RATIO_MIN  = 2;
  localparam int RATIO_MAX  = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_SETTLE
  } fd_state_e;

  // Legal ratios are even and inside [RATIO_MIN, RATIO_MAX].
  function automatic logic ratio_ok(input int r);
    return (r[0] == 1'b0) && (r >= RATIO_MIN) && (r <= RATIO_MAX);
  endfunction

endpackage

// File: rtl/fd_prog.sv
// Programmable even divider: toggles div_out every `half` enabled clocks.
// A load restarts the low phase so a new half-period starts without a runt.
module fd_prog #(
  parameter int HALF_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_en,
  input  logic [HALF_W-1:0] half,
  input  logic              load,
  output logic              div_out,
  output logic [HALF_W-1:0] cnt
);

  logic              r_div_out;
  logic [HALF_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || !div_en) begin
      r_cnt     <= '0;
      r_div_out <= 1'b0;
    end else if (load) begin
      r_cnt     <= HALF_W'(1);
      r_div_out <= 1'b0;
    end else if (r_cnt == half) begin
      r_cnt     <= HALF_W'(1);
      r_div_out <= ~r_div_out;
    end else begin
      r_cnt     <= r_cnt + HALF_W'(1);
    end
  end

  assign div_out = r_div_out;
  assign cnt     = r_cnt;

endmodule

// File: rtl/fd_ratio_ctrl.sv
// Ratio-change controller: accepts a new divide ratio and applies it on the
// next high-to-low toggle of div_out, then waits a few falling edges.
module fd_ratio_ctrl
  import fd_pkg::*;
#(
  parameter int RATIO_W       = FD_RATIO_W,
  parameter int DEFAULT_RATIO = 4,
  parameter int SETTLE_EDGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_en,
  input  logic               req_valid,
  input  logic [RATIO_W-1:0] req_ratio,
  output logic               req_ready,
  output logic               div_out,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               busy,
  output logic               err
);

  localparam int HALF_W = RATIO_W - 1;
  localparam int SET_W  = (SETTLE_EDGES < 2) ? 1 : $clog2(SETTLE_EDGES);

  fd_state_e          r_state, w_next;
  logic [HALF_W-1:0]  r_half;
  logic [RATIO_W-1:0] r_pend;
  logic [SET_W-1:0]   r_settle;
  logic               r_err;

  logic               w_accept, w_load, w_fall, w_div_out;
  logic [HALF_W-1:0]  w_cnt, w_pend_half;

  fd_prog #(.HALF_W(HALF_W)) u_prog (
    .clk     (clk),
    .rst     (rst),
    .div_en  (div_en),
    .half    (r_half),
    .load    (w_load),
    .div_out (w_div_out),
    .cnt     (w_cnt)
  );

  // The divider is about to drive div_out from high to low on this edge.
  assign w_fall      = div_en && (w_cnt == r_half) && w_div_out;
  assign w_pend_half = HALF_W'(r_pend >> 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (ratio_ok(int'(req_ratio))) w_next = ST_WAIT_EDGE;
        end
      end
      ST_WAIT_EDGE: begin
        if (!div_en || w_fall) begin
          w_load = 1'b1;
          w_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!div_en)
          w_next = ST_IDLE;
        else if (w_fall && (r_settle == SET_W'(SETTLE_EDGES - 1)))
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_half   <= HALF_W'(DEFAULT_RATIO / 2);
      r_pend   <= RATIO_W'(DEFAULT_RATIO);
      r_settle <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && !ratio_ok(int'(req_ratio));
      if (w_accept) r_pend <= req_ratio;
      if (w_load)   r_half <= w_pend_half;
      if (w_next != ST_SETTLE)
        r_settle <= '0;
      else if ((r_state == ST_SETTLE) && w_fall)
        r_settle <= r_settle + SET_W'(1);
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;
  assign div_out   = w_div_out;
  assign cur_ratio = {r_half, 1'b0};

endmodule
